// File: rtl/ntt_layer_scheduler.sv
// Kyber NTT layer scheduler: walks 7 butterfly layers, issues reads/zetas, aligns write-back.
// Optional NTT_LAYER_SCHED_PERF_EN adds a 16-bit busy-cycle counter output (cycle_cnt).
module ntt_layer_scheduler #(
    parameter int RAM_LAT = 1,
    parameter int BFU_LAT = 3,
    parameter int ADDR_W  = 8
) (
    input  logic              clk,
    input  logic              r,
    input  logic              start,
    input  logic              inverse,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr_a,
    output logic [ADDR_W-1:0] rd_addr_b,
    output logic [6:0]        zeta_idx,
    output logic              bfu_valid_in,
    output logic              bfu_inverse,
    input  logic              bfu_valid_out,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr_a,
    output logic [ADDR_W-1:0] wr_addr_b,
    output logic              err
`ifdef NTT_LAYER_SCHED_PERF_EN
    ,
    output logic [15:0]       cycle_cnt
`endif
);

    localparam int PIPE_LAT = RAM_LAT + BFU_LAT;
    localparam int DW       = $clog2(PIPE_LAT + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t        state, state_next;
    logic [2:0]    layer, layer_next;
    logic [6:0]    bfly, bfly_next;
    logic [DW-1:0] drain_cnt, drain_next;
    logic          inv_q;

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            state     <= IDLE;
            layer     <= '0;
            bfly      <= '0;
            drain_cnt <= '0;
            inv_q     <= 1'b0;
        end else begin
            state     <= state_next;
            layer     <= layer_next;
            bfly      <= bfly_next;
            drain_cnt <= drain_next;
            if (state == IDLE && start)
                inv_q <= inverse;
        end
    end

    // NOTE: every always_comb output is assigned a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        layer_next = layer;
        bfly_next  = bfly;
        drain_next = drain_cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    layer_next = '0;
                    bfly_next  = '0;
                end
            end
            RUN: begin
                bfly_next = bfly + 7'd1;
                if (bfly == 7'd127) begin
                    state_next = DRAIN;
                    drain_next = '0;
                end
            end
            DRAIN: begin
                if (drain_cnt == DW'(PIPE_LAT - 1)) begin
                    drain_next = '0;
                    if (layer == 3'd6) begin
                        state_next = DONE;
                    end else begin
                        state_next = RUN;
                        layer_next = layer + 3'd1;
                        bfly_next  = '0;
                    end
                end else begin
                    drain_next = drain_cnt + DW'(1);
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Layer length L = 2^shift; g = b / L, j = b mod L, all done with shifts and masks.
    logic [3:0] shift;
    logic [7:0] b_ext, len, j, g, addr_a, addr_b, zeta_full;

    always_comb begin
        shift     = inv_q ? (4'(layer) + 4'd1) : (4'd7 - 4'(layer));
        b_ext     = {1'b0, bfly};
        len       = 8'd1 << shift;
        j         = b_ext & (len - 8'd1);
        g         = b_ext >> shift;
        addr_a    = (g << (shift + 4'd1)) | j;
        addr_b    = addr_a + len;
        zeta_full = inv_q ? ((8'd1 << (4'd8 - shift)) - 8'd1 - g)
                          : ((8'd1 << (4'd7 - shift)) + g);
    end

    assign rd_en     = (state == RUN);
    assign rd_addr_a = rd_en ? ADDR_W'(addr_a) : '0;
    assign rd_addr_b = rd_en ? ADDR_W'(addr_b) : '0;
    assign busy      = (state == RUN) || (state == DRAIN);
    assign done      = (state == DONE);

    logic              vin_pipe  [RAM_LAT];
    logic [6:0]        zeta_pipe [RAM_LAT];
    logic              wr_pipe   [PIPE_LAT];
    logic [ADDR_W-1:0] wa_pipe   [PIPE_LAT];
    logic [ADDR_W-1:0] wb_pipe   [PIPE_LAT];

    // NOTE: the delay lines are plain flops (not RAM) and are reset so a mid-run reset leaves no stale strobes.
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            for (int i = 0; i < RAM_LAT; i++) begin
                vin_pipe[i]  <= 1'b0;
                zeta_pipe[i] <= '0;
            end
            for (int i = 0; i < PIPE_LAT; i++) begin
                wr_pipe[i] <= 1'b0;
                wa_pipe[i] <= '0;
                wb_pipe[i] <= '0;
            end
        end else begin
            vin_pipe[0]  <= rd_en;
            zeta_pipe[0] <= rd_en ? zeta_full[6:0] : 7'd0;
            for (int i = 1; i < RAM_LAT; i++) begin
                vin_pipe[i]  <= vin_pipe[i-1];
                zeta_pipe[i] <= zeta_pipe[i-1];
            end
            wr_pipe[0] <= rd_en;
            wa_pipe[0] <= rd_addr_a;
            wb_pipe[0] <= rd_addr_b;
            for (int i = 1; i < PIPE_LAT; i++) begin
                wr_pipe[i] <= wr_pipe[i-1];
                wa_pipe[i] <= wa_pipe[i-1];
                wb_pipe[i] <= wb_pipe[i-1];
            end
        end
    end

    assign bfu_valid_in = vin_pipe[RAM_LAT-1];
    assign zeta_idx     = zeta_pipe[RAM_LAT-1];
    assign bfu_inverse  = inv_q;
    assign wr_en        = wr_pipe[PIPE_LAT-1];
    assign wr_addr_a    = wa_pipe[PIPE_LAT-1];
    assign wr_addr_b    = wb_pipe[PIPE_LAT-1];

    // Sticky: the butterfly's valid_out must track the scheduler's own write strobe.
    always_ff @(posedge clk or negedge r) begin
        if (!r)
            err <= 1'b0;
        else if (bfu_valid_out != wr_en)
            err <= 1'b1;
    end

`ifdef NTT_LAYER_SCHED_PERF_EN
    always_ff @(posedge clk or negedge r) begin
        if (!r)
            cycle_cnt <= '0;
        else if (state == IDLE && start)
            cycle_cnt <= '0;
        else if (state != IDLE)
            cycle_cnt <= cycle_cnt + 16'd1;
    end
`endif

endmodule
